// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient-load path.
//   state_t    : burst sequencer states (IDLE, LOAD, DONE), 2-bit encoding
//   STROBE_OFF : level of an inactive active-low write strobe bit; replicate
//                it to NUM_TAPS bits for the all-ones "no write" pattern
// ---------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/onehot_dec_n.sv
// ---------------------------------------------------------------------------
// onehot_dec_n
// Combinational ADDR_W-to-NUM_TAPS active-low one-hot decoder with enable.
// Ports:
//   addr  in  ADDR_W    address to decode
//   en    in  1         decode enable; low forces all outputs inactive (1)
//   dec_n out NUM_TAPS  active-low one-hot; all ones for en=0 or addr>=NUM_TAPS
// ---------------------------------------------------------------------------
module onehot_dec_n
    import fir_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int NUM_TAPS = 16
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_TAPS-1:0] dec_n
);

    // Only addresses 0..NUM_TAPS-1 have a matching bit, so an out-of-range
    // address naturally leaves every strobe inactive.
    always_comb begin
        dec_n = {NUM_TAPS{STROBE_OFF}};
        if (en) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (addr == ADDR_W'(i)) begin
                    dec_n[i] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/coef_wr_seq.sv
// ---------------------------------------------------------------------------
// coef_wr_seq
// Burst sequencer that turns a stream of coefficient words into registered,
// one-cycle, active-low one-hot write strobes for the tap coefficient bank.
// Supports a programmable start tap, burst length, auto-increment with wrap,
// a valid/ready input handshake and abort.
// Ports:
//   clk        in  1         system clock
//   rst        in  1         asynchronous active-high reset
//   start      in  1         burst request, sampled only in IDLE
//   start_addr in  ADDR_W    first tap of the burst
//   burst_len  in  ADDR_W+1  words in the burst, 0..NUM_TAPS
//   abort      in  1         cancel an active burst
//   wr_valid   in  1         upstream word valid
//   wr_ready   out 1         word accepted this cycle when wr_valid is high
//   wr_data    in  DATA_W    coefficient word
//   wen_n      out NUM_TAPS  registered active-low one-hot write strobes
//   wdata      out DATA_W    registered write data aligned with wen_n
//   busy       out 1         high in LOAD and DONE
//   done       out 1         one-cycle pulse at burst completion
//   err        out 1         one-cycle pulse on an illegal start request
// ---------------------------------------------------------------------------
module coef_wr_seq
    import fir_pkg::*;
#(
    parameter int ADDR_W   = 4,
    parameter int NUM_TAPS = 16,
    parameter int DATA_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W:0]     burst_len,
    input  logic                abort,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [NUM_TAPS-1:0] wen_n,
    output logic [DATA_W-1:0]   wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W:0]   TAP_CNT   = (ADDR_W + 1)'(NUM_TAPS);

    state_t                state;
    logic [ADDR_W-1:0]     addr;
    logic [ADDR_W:0]       remaining;
    logic                  accept;
    logic [NUM_TAPS-1:0]   strobe_n;

    // Ready comes from registered state and abort only, never from wr_valid,
    // so upstream sees no combinational loop through this block.
    assign wr_ready = (state == LOAD) && !abort;
    assign accept   = wr_valid && wr_ready;

    onehot_dec_n #(
        .ADDR_W   (ADDR_W),
        .NUM_TAPS (NUM_TAPS)
    ) u_dec (
        .addr  (addr),
        .en    (accept),
        .dec_n (strobe_n)
    );

    // Strobe/data register: one cycle after the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_n <= {NUM_TAPS{STROBE_OFF}};
            wdata <= '0;
        end else begin
            wen_n <= strobe_n;
            if (accept) begin
                wdata <= wr_data;
            end
        end
    end

    // Sequencer: state, tap pointer, beat count and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (({1'b0, start_addr} >= TAP_CNT) || (burst_len > TAP_CNT)) begin
                            err <= 1'b1;
                        end else if (burst_len == '0) begin
                            // Empty burst completes at once without a strobe
                            done <= 1'b1;
                        end else begin
                            addr      <= start_addr;
                            remaining <= burst_len;
                            busy      <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (accept) begin
                        addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        // Last beat: done lines up with the final strobe
                        if (remaining == (ADDR_W + 1)'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coef_wr_seq.sv
// ---------------------------------------------------------------------------
// tb_coef_wr_seq
// Drives a 16-tap and an 11-tap instance of coef_wr_seq from the same inputs
// and compares every cycle against a behavioural burst model per instance.
// ---------------------------------------------------------------------------
module tb_coef_wr_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  start_addr;
    logic [4:0]  burst_len;
    logic        abort;
    logic        wr_valid;
    logic [15:0] wr_data;

    logic        rdy16, busy16, done16, err16;
    logic [15:0] wen16, wd16;
    logic        rdy11, busy11, done11, err11;
    logic [10:0] wen11;
    logic [15:0] wd11;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coef_wr_seq #(.ADDR_W(4), .NUM_TAPS(16), .DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .burst_len(burst_len), .abort(abort), .wr_valid(wr_valid),
        .wr_ready(rdy16), .wr_data(wr_data), .wen_n(wen16), .wdata(wd16),
        .busy(busy16), .done(done16), .err(err16)
    );

    coef_wr_seq #(.ADDR_W(4), .NUM_TAPS(11), .DATA_W(16)) dut11 (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .burst_len(burst_len), .abort(abort), .wr_valid(wr_valid),
        .wr_ready(rdy11), .wr_data(wr_data), .wen_n(wen11), .wdata(wd11),
        .busy(busy11), .done(done11), .err(err11)
    );

    // Reference model, index 0 = 16 taps, index 1 = 11 taps.
    // active: burst in progress; tail: the completion cycle after the last beat.
    int ntaps [2] = '{16, 11};
    bit active [2];
    bit tail   [2];
    int tap    [2];
    int left   [2];
    int e_wen  [2];
    int e_wd   [2];
    bit e_busy [2];
    bit e_done [2];
    bit e_err  [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int all_off(input int k);
        return (1 << ntaps[k]) - 1;
    endfunction

    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            bit take;
            if (rst) begin
                active[k] = 0; tail[k] = 0; tap[k] = 0; left[k] = 0;
                e_wen[k] = all_off(k); e_wd[k] = 0;
                e_done[k] = 0; e_err[k] = 0; e_busy[k] = 0;
                continue;
            end
            take = active[k] && !abort && wr_valid;
            e_wen[k]  = take ? (all_off(k) & ~(1 << tap[k])) : all_off(k);
            if (take) e_wd[k] = int'(wr_data);
            e_done[k] = 0;
            e_err[k]  = 0;
            if (tail[k]) begin
                tail[k] = 0;
            end else if (active[k]) begin
                if (abort) begin
                    active[k] = 0;
                end else if (take) begin
                    tap[k]  = (tap[k] + 1) % ntaps[k];
                    left[k] = left[k] - 1;
                    if (left[k] == 0) begin
                        active[k] = 0;
                        tail[k]   = 1;
                        e_done[k] = 1;
                    end
                end
            end else if (start) begin
                if (int'(start_addr) >= ntaps[k] || int'(burst_len) > ntaps[k]) begin
                    e_err[k] = 1;
                end else if (burst_len == 0) begin
                    e_done[k] = 1;
                end else begin
                    active[k] = 1;
                    tap[k]    = int'(start_addr);
                    left[k]   = int'(burst_len);
                end
            end
            e_busy[k] = active[k] || tail[k];
        end
    endfunction

    task automatic check_outputs();
        check_val("wen16",  32'(wen16),  e_wen[0]);
        check_val("wdata16", 32'(wd16),  e_wd[0]);
        check_val("busy16", 32'(busy16), 32'(e_busy[0]));
        check_val("done16", 32'(done16), 32'(e_done[0]));
        check_val("err16",  32'(err16),  32'(e_err[0]));
        check_val("wen11",  32'(wen11),  e_wen[1]);
        check_val("wdata11", 32'(wd11),  e_wd[1]);
        check_val("busy11", 32'(busy11), 32'(e_busy[1]));
        check_val("done11", 32'(done11), 32'(e_done[1]));
        check_val("err11",  32'(err11),  32'(e_err[1]));
    endtask

    // Apply one cycle of inputs (called just after a falling edge)
    task automatic tick(input bit st, input int sa, input int bl,
                        input bit ab, input bit v, input int d);
        start      = st;
        start_addr = sa[3:0];
        burst_len  = bl[4:0];
        abort      = ab;
        wr_valid   = v;
        wr_data    = d[15:0];
        #1;
        check_val("ready16", 32'(rdy16), 32'(active[0] && !ab && !rst));
        check_val("ready11", 32'(rdy11), 32'(active[1] && !ab && !rst));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 0; start_addr = 0; burst_len = 0;
        abort = 0; wr_valid = 0; wr_data = 0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;
        idle(2);

        // Full 16-beat burst (illegal length for the 11-tap instance)
        tick(1, 0, 16, 0, 0, 0);
        for (int i = 0; i < 16; i++) tick(0, 0, 0, 0, 1, 'h0100 + i);
        idle(3);

        // Wrap: taps 14, 15, 0, 1
        tick(1, 14, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 'h0A00 + i);
        idle(3);

        // Gaps in wr_valid
        tick(1, 2, 3, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 'h1111);
        tick(0, 0, 0, 0, 0, 'h2222);
        tick(0, 0, 0, 0, 0, 'h3333);
        tick(0, 0, 0, 0, 1, 'h4444);
        tick(0, 0, 0, 0, 1, 'h5555);
        idle(3);

        // Illegal start address (11 taps), illegal length, zero length
        tick(1, 12, 2, 0, 0, 0);
        idle(2);
        tick(1, 0, 17, 0, 0, 0);
        idle(2);
        tick(1, 5, 0, 0, 0, 0);
        idle(2);

        // Abort with wr_valid high after 2 of 5 beats
        tick(1, 3, 5, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 'hAA01);
        tick(0, 0, 0, 0, 1, 'hAA02);
        tick(0, 0, 0, 1, 1, 'hAA03);
        idle(3);

        // 11-tap wrap: taps 9, 10, 0, 1
        tick(1, 9, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 'hB000 + i);
        idle(3);

        // Asynchronous reset between edges while a strobe is showing
        tick(1, 1, 6, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 'hC0DE);
        #1 rst = 1'b1;
        #1;
        check_val("async_wen16", 32'(wen16), 32'hFFFF);
        check_val("async_wen11", 32'(wen11), 32'h07FF);
        check_val("async_busy16", 32'(busy16), 32'h0);
        tick(0, 0, 0, 0, 1, 'hC0DF);
        rst = 1'b0;
        idle(2);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 17), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
